// File: rtl/memory_dp_clr.sv
// Dual-port RAM (1W/1R) with per-byte write enables, a zeroing clear engine and write-first forwarding.
// Define MEMORY_DP_OUTREG_EN for an extra output register stage (read latency 2 instead of 1).

module memory_dp_clr_lane #(
  parameter int AW = 10,
  localparam int MD = 1 << AW
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [MD];
  logic [7:0] rd_d, rd_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Write-first: a same-cycle write to the read address returns the new byte
  always_comb begin
    rd_d = rd_q;
    if (re) rd_d = (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) rd_q <= '0;
    else         rd_q <= rd_d;
  end

  assign rdata = rd_q;
endmodule

module memory_dp_clr #(
  parameter int AW = 10,
  parameter int DW = 64,
  localparam int WED = DW / 8,
  localparam int MD  = 1 << AW
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           clear,
  input  logic [WED-1:0] wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [DW-1:0]  wr_data,
  input  logic           rd_en,
  input  logic [AW-1:0]  rd_addr,
  output logic [DW-1:0]  rd_data,
  output logic           rd_valid,
  output logic           ready
);
`ifdef MEMORY_DP_OUTREG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic                clearing, rd_issue;
  logic [WED-1:0]      lane_we;
  logic [AW-1:0]       lane_waddr;
  logic [WED-1:0][7:0] lane_wdata;
  logic [WED-1:0][7:0] arr_rd;
  logic [STAGES:1]     vld_pipe_q, vld_pipe_d;

  assign clearing = (state_q == S_CLEAR);
  assign ready    = (state_q == S_READY);
  assign rd_issue = ready & rd_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(MD - 1)) state_d = S_READY;
      end
      S_READY: begin
        if (clear) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The clear engine owns the write port while clearing; user traffic is dropped
  assign lane_waddr = clearing ? cnt_q : wr_addr;
  assign lane_wdata = clearing ? '0 : wr_data;
  assign lane_we    = clearing ? '1 : (ready ? wr_en : '0);

  for (genvar i = 0; i < WED; i++) begin : g_lane
    memory_dp_clr_lane #(.AW(AW)) u_lane (
      .clk   (clk),
      .nreset(nreset),
      .we    (lane_we[i]),
      .waddr (lane_waddr),
      .wdata (lane_wdata[i]),
      .re    (rd_issue),
      .raddr (rd_addr),
      .rdata (arr_rd[i])
    );
  end

  // Valid shift register runs regardless of state so in-flight reads finish
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    vld_pipe_d[1] = rd_issue;
    for (int k = 2; k <= STAGES; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) vld_pipe_q <= '0;
    else         vld_pipe_q <= vld_pipe_d;
  end

  assign rd_valid = vld_pipe_q[STAGES];

`ifdef MEMORY_DP_OUTREG_EN
  logic [DW-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (vld_pipe_q[1]) rd_data_d = arr_rd;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) rd_data_q <= '0;
    else         rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`else
  assign rd_data = arr_rd;
`endif
endmodule
